aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller. Accepts one 128-bit plaintext block over a valid/ready handshake and applies the initial AddRoundKey itself. It then issues rounds 1..NR to the shared round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey chain) as 132-bit header-tagged packets and returns the ciphertext over a valid/ready handshake. It sits between the host interface and the round datapath and drives the round-key index to the key-schedule store.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_round_sequencer.sv | 122 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
//   seq_state_t : sequencer FSM states
//   pkt_t       : {header, data} packet exchanged with the round datapath
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

  localparam int         AES_NR     = 10;
  localparam int         HDR_W      = 4;
  localparam logic [3:0] HDR_BUBBLE = 4'd0;
  localparam int         BLK_W      = 128;

  // Header carries the round number; header NR tells the datapath to skip
  // MixColumns, header 0 marks an empty slot.
  typedef struct packed {
    logic [HDR_W-1:0] header;
    logic [BLK_W-1:0] data;
  } pkt_t;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller.
// Accepts a plaintext block, applies the initial AddRoundKey, then sends
// rounds 1..NR to the external round datapath one at a time and returns the
// ciphertext.
//   clk, n_rst              : clock, async active-low reset
//   in_valid/in_ready/in_data     : plaintext handshake
//   out_valid/out_ready/out_data  : ciphertext handshake
//   rk_idx/rk_data          : round-key request / combinational key return
//   dp_enable/dp_data_out   : one-cycle packet {round, state} to the datapath
//   dp_data_in              : packet returned by the datapath
//   busy                    : block in flight (ISSUE or WAIT)
//   err                     : sticky returned-header mismatch
// Header width is aes_pkg::HDR_W.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int DP_LATENCY = 1       // 1..15
)(
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLK_W-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLK_W-1:0]       out_data,
  output logic [3:0]             rk_idx,
  input  logic [BLK_W-1:0]       rk_data,
  output logic                   dp_enable,
  output logic [BLK_W+HDR_W-1:0] dp_data_out,
  input  logic [BLK_W+HDR_W-1:0] dp_data_in,
  output logic                   busy,
  output logic                   err
);

  seq_state_t       state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [3:0]       wcnt_q,  wcnt_d;
  logic [BLK_W-1:0] blk_q,   blk_d;
  logic             err_q,   err_d;
  pkt_t             pkt_out, pkt_in;

  assign pkt_in      = dp_data_in;
  assign dp_data_out = pkt_out;
  assign err         = err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      round_q <= '0;
      wcnt_q  <= '0;
      blk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wcnt_q  <= wcnt_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    wcnt_d         = wcnt_q;
    blk_d          = blk_q;
    err_d          = err_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    dp_enable      = 1'b0;
    pkt_out.header = HDR_BUBBLE;
    pkt_out.data   = '0;
    rk_idx         = round_q;
    busy           = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = '0;
        if (in_valid) begin
          // rk_idx is 0 here, so rk_data is the cipher key: initial AddRoundKey
          blk_d   = in_data ^ rk_data;
          round_d = 4'd1;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy           = 1'b1;
        dp_enable      = 1'b1;
        pkt_out.header = round_q;
        pkt_out.data   = blk_q;
        wcnt_d         = 4'(DP_LATENCY);
        state_d        = WAIT;
      end
      WAIT: begin
        busy   = 1'b1;
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          blk_d = pkt_in.data;
          // A wrong header is flagged but the round is still taken.
          if (pkt_in.header != round_q) err_d = 1'b1;
          if (round_q == 4'(NR)) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = blk_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: two instances (DP_LATENCY 1 and 3),
// each with a key-store array and a behavioural AES round datapath.
module tb_aes_round_sequencer;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [127:0] in_data1 = '0, out_data1, rk_data1;
  logic [3:0]   rk_idx1;
  logic         dp_enable1, busy1, err1;
  logic [131:0] dp_data_out1, dp_data_in1;

  logic         in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0;
  logic [127:0] in_data3 = '0, out_data3, rk_data3;
  logic [3:0]   rk_idx3;
  logic         dp_enable3, busy3, err3;
  logic [131:0] dp_data_out3, dp_data_in3;

  aes_round_sequencer #(.NR(10), .DP_LATENCY(1)) u1 (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .rk_idx(rk_idx1), .rk_data(rk_data1),
    .dp_enable(dp_enable1), .dp_data_out(dp_data_out1), .dp_data_in(dp_data_in1),
    .busy(busy1), .err(err1)
  );

  aes_round_sequencer #(.NR(10), .DP_LATENCY(3)) u3 (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .rk_idx(rk_idx3), .rk_data(rk_data3),
    .dp_enable(dp_enable3), .dp_data_out(dp_data_out3), .dp_data_in(dp_data_in3),
    .busy(busy3), .err(err3)
  );

  // ---------------- AES reference pieces ----------------
  logic [7:0]   sbox [0:255];
  logic [127:0] rk_mem [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a_i, input logic [7:0] b_i);
    logic [7:0] a, b, p;
    a = a_i; b = b_i; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input bit last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) m[r+4*c] = t[r+4*c];
      end else begin
        m[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
        m[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
        m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
        m[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = m[i] ^ k[127-8*i -: 8];
    return res;
  endfunction

  // ---------------- key store and datapath models ----------------
  int corrupt = 0;  // round whose returned header is forced to 0 (0 = none)

  assign rk_data1 = rk_mem[rk_idx1];
  assign rk_data3 = rk_mem[rk_idx3];

  function automatic logic [131:0] dp_model(input logic [131:0] p, input logic [127:0] k);
    logic [3:0] h;
    h = p[131:128];
    return {(corrupt != 0 && int'(h) == corrupt) ? 4'd0 : h,
            aes_round(p[127:0], k, h == 4'd10)};
  endfunction

  logic [131:0] pipe1;
  logic [131:0] pipe3 [0:2];
  always @(posedge clk) begin
    pipe1    <= dp_enable1 ? dp_model(dp_data_out1, rk_data1) : '0;
    pipe3[0] <= dp_enable3 ? dp_model(dp_data_out3, rk_data3) : '0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign dp_data_in1 = pipe1;
  assign dp_data_in3 = pipe3[2];

  // ---------------- packet logger ----------------
  int cyc_ctr = 0;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  logic [3:0] hq1[$], rq1[$], hq3[$], rq3[$];
  int         tq1[$], tq3[$];
  always @(negedge clk) begin
    if (dp_enable1) begin hq1.push_back(dp_data_out1[131:128]); rq1.push_back(rk_idx1); tq1.push_back(cyc_ctr); end
    if (dp_enable3) begin hq3.push_back(dp_data_out3[131:128]); rq3.push_back(rk_idx3); tq3.push_back(cyc_ctr); end
  end

  // ---------------- checking helpers ----------------
  int   n_cmp = 0;
  int   n_err = 0;
  logic err_hist [0:127];

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ov(input int sel);
    return (sel == 3) ? out_valid3 : out_valid1;
  endfunction

  function automatic logic er(input int sel);
    return (sel == 3) ? err3 : err1;
  endfunction

  // Present a block, take the accepting edge, then count cycles to out_valid.
  task automatic run_block(input int sel, input logic [127:0] pt, input int budget, output int cyc);
    if (sel == 3) begin hq3.delete(); rq3.delete(); tq3.delete(); in_data3 = pt; in_valid3 = 1'b1; end
    else          begin hq1.delete(); rq1.delete(); tq1.delete(); in_data1 = pt; in_valid1 = 1'b1; end
    tick();
    in_valid1 = 1'b0;
    in_valid3 = 1'b0;
    cyc = 0;
    err_hist[0] = er(sel);
    while (cyc < budget && !ov(sel)) begin
      tick();
      cyc++;
      err_hist[cyc] = er(sel);
    end
  endtask

  task automatic chk_pkts(input int sel, input int spacing, input string pfx);
    logic [3:0] h[$], r[$];
    int         t[$];
    if (sel == 3) begin h = hq3; r = rq3; t = tq3; end
    else          begin h = hq1; r = rq1; t = tq1; end
    chk({pfx, "_npkts"}, 132'(h.size()), 132'(10));
    for (int i = 0; i < h.size() && i < 10; i++) begin
      chk($sformatf("%s_hdr%0d", pfx, i+1), 132'(h[i]), 132'(i+1));
      chk($sformatf("%s_rk%0d", pfx, i+1), 132'(r[i]), 132'(i+1));
      if (i > 0) chk($sformatf("%s_gap%0d", pfx, i+1), 132'(t[i]-t[i-1]), 132'(spacing));
    end
  endtask

  task automatic release_out(input int sel, input string pfx);
    if (sel == 3) out_ready3 = 1'b1; else out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    out_ready3 = 1'b0;
    chk({pfx, "_ov_fall"}, 132'(ov(sel)), 132'(0));
    chk({pfx, "_inrdy_rise"}, 132'((sel == 3) ? in_ready3 : in_ready1), 132'(1));
    chk({pfx, "_odata_zero"}, 132'((sel == 3) ? out_data3 : out_data1), 132'(0));
  endtask

  task automatic chk_reset1(input string pfx);
    chk({pfx, "_ov"},    132'(out_valid1),   132'(0));
    chk({pfx, "_odata"}, 132'(out_data1),    132'(0));
    chk({pfx, "_dpen"},  132'(dp_enable1),   132'(0));
    chk({pfx, "_dpout"}, dp_data_out1,       132'(0));
    chk({pfx, "_rkidx"}, 132'(rk_idx1),      132'(0));
    chk({pfx, "_busy"},  132'(busy1),        132'(0));
    chk({pfx, "_err"},   132'(err1),         132'(0));
    chk({pfx, "_inrdy"}, 132'(in_ready1),    132'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    build_sbox();
    expand_key(K1);

    // 1. reset with random inputs
    #1 n_rst = 1'b0;
    repeat (4) begin
      tick();
      in_valid1  = 1'($urandom);
      in_data1   = {$urandom, $urandom, $urandom, $urandom};
      out_ready1 = 1'($urandom);
      in_valid3  = 1'($urandom);
      out_ready3 = 1'($urandom);
    end
    chk_reset1("rst");
    chk("rst_u3_inrdy", 132'(in_ready3), 132'(1));
    chk("rst_u3_busy",  132'(busy3),     132'(0));
    n_rst = 1'b1;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b0;
    tick();
    chk("rst_inrdy_after", 132'(in_ready1), 132'(1));

    // 2. FIPS-197 vector, DP_LATENCY=1
    chk("t2_rkidx_idle", 132'(rk_idx1), 132'(0));
    run_block(1, PT1, 40, cyc);
    chk("t2_latency", 132'(cyc), 132'(20));
    chk("t2_ct", 132'(out_data1), 132'(CT1));
    chk("t2_err", 132'(err1), 132'(0));
    chk("t2_inrdy_done", 132'(in_ready1), 132'(0));
    chk("t2_busy_done", 132'(busy1), 132'(0));
    chk_pkts(1, 2, "t2");
    release_out(1, "t2");

    // 3. DP_LATENCY=3, same vector
    run_block(3, PT1, 60, cyc);
    chk("t3_latency", 132'(cyc), 132'(40));
    chk("t3_ct", 132'(out_data3), 132'(CT1));
    chk("t3_err", 132'(err3), 132'(0));
    chk_pkts(3, 4, "t3");
    release_out(3, "t3");

    // 4. backpressure in DONE; stray in_valid must be ignored
    run_block(1, PT1, 40, cyc);
    chk("t4_latency", 132'(cyc), 132'(20));
    in_valid1 = 1'b1;
    in_data1  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_hold_data%0d", i), 132'(out_data1), 132'(CT1));
      chk($sformatf("t4_hold_inrdy%0d", i), 132'(in_ready1), 132'(0));
      chk($sformatf("t4_hold_ov%0d", i), 132'(out_valid1), 132'(1));
    end
    in_valid1 = 1'b0;
    release_out(1, "t4");
    expand_key(K2);
    run_block(1, PT2, 40, cyc);
    chk("t4_b2_latency", 132'(cyc), 132'(20));
    chk("t4_b2_ct", 132'(out_data1), 132'(CT2));
    release_out(1, "t4b2");
    expand_key(K1);

    // 5. header mismatch on round 4
    corrupt = 4;
    run_block(1, PT1, 40, cyc);
    corrupt = 0;
    chk("t5_err_before", 132'(err_hist[7]), 132'(0));
    chk("t5_err_at_cap", 132'(err_hist[8]), 132'(1));
    chk("t5_latency", 132'(cyc), 132'(20));
    chk("t5_ct", 132'(out_data1), 132'(CT1));
    chk("t5_err_done", 132'(err1), 132'(1));
    release_out(1, "t5");
    chk("t5_err_idle", 132'(err1), 132'(1));
    run_block(1, PT1, 40, cyc);
    chk("t5_err_cleared", 132'(err_hist[0]), 132'(0));
    chk("t5_b2_err", 132'(err1), 132'(0));
    chk("t5_b2_ct", 132'(out_data1), 132'(CT1));
    release_out(1, "t5b2");

    // 6. reset during round 5 WAIT
    in_data1 = PT1;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    repeat (9) tick();
    chk("t6_busy_mid", 132'(busy1), 132'(1));
    chk("t6_rkidx_mid", 132'(rk_idx1), 132'(5));
    chk("t6_dpen_mid", 132'(dp_enable1), 132'(0));
    #2 n_rst = 1'b0;
    #1;
    chk_reset1("t6_async");
    @(posedge clk);
    #1 n_rst = 1'b1;
    tick();
    run_block(1, PT1, 40, cyc);
    chk("t6_latency", 132'(cyc), 132'(20));
    chk("t6_ct", 132'(out_data1), 132'(CT1));
    release_out(1, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
